// File: rtl/avg_iir_sched.sv
// avg_iir_sched: round-robin scheduler sharing one avg_iir datapath across
// N_CH channels, with credit-limited issue, FWFT result FIFO and flush/clear.
// Ports: i_clk/i_rst; i_ch_valid/i_ch_data/o_ch_ready channel inputs;
// o_iir_valid/data/ch/clr to datapath; i_iir_valid/data/ch from datapath;
// o_res_valid/data/ch with i_res_ready result stream; i_flush, o_busy, o_err.
module avg_iir_sched #(
    parameter  int N_CH       = 8,
    parameter  int DATA_W     = 24,
    parameter  int FIFO_DEPTH = 4,
    localparam int CH_W       = $clog2(N_CH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_CH-1:0]        i_ch_valid,
    input  logic [N_CH*DATA_W-1:0] i_ch_data,
    output logic [N_CH-1:0]        o_ch_ready,
    output logic                   o_iir_valid,
    output logic [DATA_W-1:0]      o_iir_data,
    output logic [CH_W-1:0]        o_iir_ch,
    output logic                   o_iir_clr,
    input  logic                   i_iir_valid,
    input  logic [DATA_W-1:0]      i_iir_data,
    input  logic [CH_W-1:0]        i_iir_ch,
    output logic                   o_res_valid,
    output logic [DATA_W-1:0]      o_res_data,
    output logic [CH_W-1:0]        o_res_ch,
    input  logic                   i_res_ready,
    input  logic                   i_flush,
    output logic                   o_busy,
    output logic                   o_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        CLEAR
    } state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = CH_W + DATA_W;

    localparam logic [CW-1:0]   CRED_MAX = CW'(FIFO_DEPTH);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(N_CH - 1);

    state_t          state_q, state_d;
    logic [CH_W-1:0] grant_q, grant_d;
    logic [CH_W-1:0] last_q, last_d;
    logic [CW-1:0]   credits_q, credits_d;
    logic            flush_q, flush_d;
    logic            err_q, err_d;
    logic [AW:0]     wr_q, rd_q;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];

    logic [DATA_W-1:0] ch_data [N_CH];
    logic [AW:0]       count;
    logic              empty, full, push, pop, issue;
    logic              rr_found;
    logic [CH_W-1:0]   rr_pick;
    logic [CH_W:0]     rr_sum;
    logic [EW-1:0]     head;

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            ch_data[k] = i_ch_data[k*DATA_W +: DATA_W];
        end
    end

    assign count = wr_q - rd_q;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop   = !empty && i_res_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = i_iir_valid && (!full || pop);
    assign issue = (state_q == ISSUE) && i_ch_valid[grant_q];
    assign head  = mem_q[rd_q[AW-1:0]];

    // Search upward from last+1 with wrap; last itself is checked last.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last_q;
        rr_sum   = '0;
        for (int i = 1; i <= N_CH; i++) begin
            rr_sum = {1'b0, last_q} + (CH_W+1)'(i);
            if (rr_sum >= (CH_W+1)'(N_CH)) begin
                rr_sum = rr_sum - (CH_W+1)'(N_CH);
            end
            if (!rr_found && i_ch_valid[rr_sum[CH_W-1:0]]) begin
                rr_found = 1'b1;
                rr_pick  = rr_sum[CH_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        flush_d     = flush_q | i_flush;
        o_ch_ready  = '0;
        o_iir_valid = 1'b0;
        o_iir_data  = '0;
        o_iir_ch    = '0;
        o_iir_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_d) begin
                    state_d = DRAIN;
                end else if (credits_q != '0 && rr_found) begin
                    grant_d = rr_pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                o_ch_ready  = N_CH'(1) << grant_q;
                o_iir_valid = i_ch_valid[grant_q];
                o_iir_data  = ch_data[grant_q];
                o_iir_ch    = grant_q;
                if (issue) begin
                    last_d = grant_q;
                end
                state_d = flush_d ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (credits_q == CRED_MAX) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                // A flush landing here is absorbed by this clear.
                o_iir_clr = 1'b1;
                flush_d   = 1'b0;
                last_d    = CH_LAST;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        credits_d = credits_q;
        if (issue && !pop) begin
            credits_d = credits_q - 1'b1;
        end else if (pop && !issue && credits_q != CRED_MAX) begin
            credits_d = credits_q + 1'b1;
        end
        err_d = err_q | (i_iir_valid && full && !pop);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= CH_LAST;
            credits_q <= CRED_MAX;
            flush_q   <= 1'b0;
            err_q     <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            credits_q <= credits_d;
            flush_q   <= flush_d;
            err_q     <= err_d;
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= {i_iir_ch, i_iir_data};
        end
    end

    assign o_res_valid = !empty;
    assign o_res_data  = empty ? '0 : head[DATA_W-1:0];
    assign o_res_ch    = empty ? '0 : head[EW-1:DATA_W];
    assign o_busy      = (state_q != IDLE) || (credits_q != CRED_MAX);
    assign o_err       = err_q;

endmodule

// File: tb/tb_avg_iir_sched.sv
// tb_avg_iir_sched: directed bench for avg_iir_sched with a two-cycle
// datapath model (result = sample >> 1) and optional result injection.
module tb_avg_iir_sched;

    localparam int N_CH = 8;
    localparam int DATA_W = 24;
    localparam int FIFO_DEPTH = 4;
    localparam int CH_W = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        i_ch_valid;
    logic [N_CH*DATA_W-1:0] i_ch_data;
    logic [N_CH-1:0]        o_ch_ready;
    logic                   o_iir_valid;
    logic [DATA_W-1:0]      o_iir_data;
    logic [CH_W-1:0]        o_iir_ch;
    logic                   o_iir_clr;
    logic                   i_iir_valid;
    logic [DATA_W-1:0]      i_iir_data;
    logic [CH_W-1:0]        i_iir_ch;
    logic                   o_res_valid;
    logic [DATA_W-1:0]      o_res_data;
    logic [CH_W-1:0]        o_res_ch;
    logic                   i_res_ready;
    logic                   i_flush;
    logic                   o_busy;
    logic                   o_err;

    logic              p0v, p1v, inj_v;
    logic [DATA_W-1:0] p0d, p1d, inj_d;
    logic [CH_W-1:0]   p0c, p1c, inj_c;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    avg_iir_sched dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ch_valid  (i_ch_valid),
        .i_ch_data   (i_ch_data),
        .o_ch_ready  (o_ch_ready),
        .o_iir_valid (o_iir_valid),
        .o_iir_data  (o_iir_data),
        .o_iir_ch    (o_iir_ch),
        .o_iir_clr   (o_iir_clr),
        .i_iir_valid (i_iir_valid),
        .i_iir_data  (i_iir_data),
        .i_iir_ch    (i_iir_ch),
        .o_res_valid (o_res_valid),
        .o_res_data  (o_res_data),
        .o_res_ch    (o_res_ch),
        .i_res_ready (i_res_ready),
        .i_flush     (i_flush),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    always @(posedge clk) begin
        if (rst) begin
            p0v <= 1'b0;
            p1v <= 1'b0;
        end else begin
            p0v <= o_iir_valid;
            p0d <= o_iir_data >> 1;
            p0c <= o_iir_ch;
            p1v <= p0v;
            p1d <= p0d;
            p1c <= p0c;
        end
    end

    assign i_iir_valid = p1v | inj_v;
    assign i_iir_data  = inj_v ? inj_d : p1d;
    assign i_iir_ch    = inj_v ? inj_c : p1c;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int n;
        int g;
        int c;
        int first;
        logic [31:0] seq;
        int exp_ch [4];

        exp_ch = '{5, 6, 7, 0};
        rst = 1'b1;
        i_ch_valid = '1;
        i_res_ready = 1'b0;
        i_flush = 1'b0;
        inj_v = 1'b0;
        inj_d = '0;
        inj_c = '0;
        for (int k = 0; k < N_CH; k++) begin
            i_ch_data[k*DATA_W +: DATA_W] = DATA_W'((k + 1) << 8);
        end

        // reset: all outputs low even with every channel valid
        step();
        step();
        chk("rst_ready", 32'(o_ch_ready), 0);
        chk("rst_iir_valid", 32'(o_iir_valid), 0);
        chk("rst_res_valid", 32'(o_res_valid), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_clr", 32'(o_iir_clr), 0);
        rst = 1'b0;

        // fairness: 0..7,0 with one idle cycle between issues
        i_res_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("fair_valid", 32'(o_iir_valid), 1);
            chk("fair_ch", 32'(o_iir_ch), k % 8);
            chk("fair_ready", 32'(o_ch_ready), 1 << (k % 8));
            step();
            chk("fair_gap", 32'(o_iir_valid), 0);
            if (k == 8) i_ch_valid = '0;
        end
        for (int w = 0; w < 20 && o_busy; w++) step();
        chk("fair_idle", 32'(o_busy), 0);
        i_res_ready = 1'b0;

        // single channel 3
        i_ch_data[3*DATA_W +: DATA_W] = 24'h000100;
        i_ch_valid = 8'h08;
        step();
        chk("s3_ready", 32'(o_ch_ready), 32'h08);
        chk("s3_valid", 32'(o_iir_valid), 1);
        chk("s3_ch", 32'(o_iir_ch), 3);
        chk("s3_data", 32'(o_iir_data), 32'h100);
        step();
        chk("s3_ready_off", 32'(o_ch_ready), 0);
        chk("s3_busy", 32'(o_busy), 1);
        i_ch_valid = '0;
        step();
        step();
        chk("s3_res_valid", 32'(o_res_valid), 1);
        chk("s3_res_data", 32'(o_res_data), 32'h80);
        chk("s3_res_ch", 32'(o_res_ch), 3);
        i_res_ready = 1'b1;
        step();
        chk("s3_popped", 32'(o_res_valid), 0);
        chk("s3_idle", 32'(o_busy), 0);
        i_res_ready = 1'b0;
        i_ch_data[3*DATA_W +: DATA_W] = 24'h000400;

        // backpressure: four credits then stall
        i_ch_valid = '1;
        n = 0;
        seq = '0;
        for (int w = 0; w < 20; w++) begin
            step();
            if (o_iir_valid) begin
                n++;
                seq = (seq << 4) | 32'(o_iir_ch);
            end
        end
        chk("bp_issues", n, 4);
        chk("bp_order", seq, 32'h4567);
        chk("bp_stall", 32'(o_ch_ready), 0);
        chk("bp_head_valid", 32'(o_res_valid), 1);
        chk("bp_head_ch", 32'(o_res_ch), 4);
        chk("bp_head_data", 32'(o_res_data), 32'h280);
        i_res_ready = 1'b1;
        step();
        i_res_ready = 1'b0;
        n = 0;
        first = -1;
        for (int w = 0; w < 10; w++) begin
            step();
            if (o_iir_valid) begin
                n++;
                if (first < 0) first = int'(o_iir_ch);
            end
        end
        chk("bp_one_more", n, 1);
        chk("bp_one_ch", first, 0);
        i_ch_valid = '0;

        // overflow: unsolicited push into a full FIFO
        chk("ov_err_before", 32'(o_err), 0);
        inj_v = 1'b1;
        inj_c = 3'd1;
        inj_d = 24'hABCDEF;
        step();
        inj_v = 1'b0;
        chk("ov_err", 32'(o_err), 1);
        i_res_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("ov_pop_valid", 32'(o_res_valid), 1);
            chk("ov_pop_ch", 32'(o_res_ch), exp_ch[j]);
            chk("ov_pop_data", 32'(o_res_data), (exp_ch[j] + 1) << 7);
            step();
        end
        chk("ov_dropped", 32'(o_res_valid), 0);
        i_res_ready = 1'b0;
        chk("ov_sticky", 32'(o_err), 1);
        step();
        chk("ov_idle", 32'(o_busy), 0);

        // flush with two results outstanding
        i_ch_valid = 8'h06;
        n = 0;
        for (int w = 0; w < 12 && n < 2; w++) begin
            step();
            if (o_iir_valid) n++;
        end
        chk("fl_issued", n, 2);
        step();
        i_ch_valid = '1;
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk("fl_no_grant", 32'(o_ch_ready), 0);
        chk("fl_busy", 32'(o_busy), 1);
        g = 0;
        c = 0;
        for (int w = 0; w < 8; w++) begin
            step();
            if (o_ch_ready != '0) g++;
            if (o_iir_clr) c++;
            i_flush = (w == 3);
        end
        i_flush = 1'b0;
        chk("fl_drain_grants", g, 0);
        chk("fl_drain_clr", c, 0);
        chk("fl_res_valid", 32'(o_res_valid), 1);
        i_res_ready = 1'b1;
        step();
        i_res_ready = 1'b0;
        for (int w = 0; w < 4; w++) begin
            step();
            if (o_ch_ready != '0) g++;
            if (o_iir_clr) c++;
        end
        chk("fl_pop1_grants", g, 0);
        chk("fl_pop1_clr", c, 0);
        chk("fl_pop2_valid", 32'(o_res_valid), 1);
        chk("fl_pop2_ch", 32'(o_res_ch), 2);
        i_res_ready = 1'b1;
        step();
        i_res_ready = 1'b0;
        c = 0;
        first = -1;
        for (int w = 0; w < 8; w++) begin
            if (o_iir_clr) c++;
            if (o_iir_valid && first < 0) first = int'(o_iir_ch);
            step();
        end
        chk("fl_clr_once", c, 1);
        chk("fl_next_ch0", first, 0);

        // reset mid-stream
        rst = 1'b1;
        #1;
        chk("mr_ready", 32'(o_ch_ready), 0);
        chk("mr_iir_valid", 32'(o_iir_valid), 0);
        chk("mr_iir_data", 32'(o_iir_data), 0);
        chk("mr_clr", 32'(o_iir_clr), 0);
        chk("mr_res_valid", 32'(o_res_valid), 0);
        chk("mr_res_data", 32'(o_res_data), 0);
        chk("mr_busy", 32'(o_busy), 0);
        chk("mr_err", 32'(o_err), 0);
        step();
        step();
        i_ch_valid = '0;
        rst = 1'b0;
        step();
        chk("mr_idle", 32'(o_busy), 0);
        chk("mr_empty", 32'(o_res_valid), 0);
        i_ch_valid = '1;
        n = 0;
        first = -1;
        for (int w = 0; w < 20; w++) begin
            step();
            if (o_iir_valid) begin
                n++;
                if (first < 0) first = int'(o_iir_ch);
            end
        end
        chk("mr_credits", n, 4);
        chk("mr_first_ch", first, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
